// File: rtl/registro_solicitudes.sv
// Elevator request register: edge-captures button codes into pending request
// vectors and runs a scan direction FSM to pick the next floor to serve.
// Optional macro CODIGO_INVALIDO_EN adds a sticky codigo_invalido output.
module registro_solicitudes (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] boton_pres,
  input  logic [1:0] piso_actual,
  input  logic       atender,
  output logic [3:0] solic_cabina,
  output logic [3:0] solic_sube,
  output logic [3:0] solic_baja,
  output logic       nueva_solicitud,
  output logic       hay_solicitud,
  output logic [1:0] direccion,
`ifdef CODIGO_INVALIDO_EN
  output logic       codigo_invalido,
`endif
  output logic [1:0] piso_destino
);

  localparam int unsigned NPISOS = 4;
  localparam logic [1:0] REPOSO   = 2'b00;
  localparam logic [1:0] SUBIENDO = 2'b01;
  localparam logic [1:0] BAJANDO  = 2'b10;

  logic [3:0] cod_prev_q, cod_prev_d;
  logic [3:0] cabina_q, cabina_d;
  logic [3:0] sube_q, sube_d;
  logic [3:0] baja_q, baja_d;
  logic       nueva_q, nueva_d;
  logic       hay_q, hay_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] destino_q, destino_d;
`ifdef CODIGO_INVALIDO_EN
  logic       invalido_q, invalido_d;
`endif

  logic       aceptado;
  logic [3:0] set_cab, set_sub, set_baj, clr_mask;
  logic [3:0] req;
  logic       arriba, abajo;

  // Decode an accepted (new, valid, nonzero) code into a set mask
  always_comb begin
    set_cab  = 4'b0000;
    set_sub  = 4'b0000;
    set_baj  = 4'b0000;
    aceptado = (boton_pres != 4'd0) && (boton_pres <= 4'd10) && (boton_pres != cod_prev_q);
    if (aceptado) begin
      case (boton_pres)
        4'd1:    set_cab = 4'b0001;
        4'd2:    set_cab = 4'b0010;
        4'd3:    set_cab = 4'b0100;
        4'd4:    set_cab = 4'b1000;
        4'd5:    set_sub = 4'b0001;
        4'd6:    set_baj = 4'b0010;
        4'd7:    set_sub = 4'b0010;
        4'd8:    set_baj = 4'b0100;
        4'd9:    set_sub = 4'b0100;
        4'd10:   set_baj = 4'b1000;
        default: ;
      endcase
    end
  end

  // Request vector update; clear has priority over set on the same bit
  always_comb begin
    clr_mask   = atender ? (4'b0001 << piso_actual) : 4'b0000;
    cod_prev_d = boton_pres;
    cabina_d   = (cabina_q | set_cab) & ~clr_mask;
    sube_d     = (sube_q | set_sub) & ~clr_mask & 4'b0111;
    baja_d     = (baja_q | set_baj) & ~clr_mask & 4'b1110;
    nueva_d    = |((cabina_d & ~cabina_q) | (sube_d & ~sube_q) | (baja_d & ~baja_q));
    hay_d      = |(cabina_d | sube_d | baja_d);
  end

`ifdef CODIGO_INVALIDO_EN
  always_comb begin
    invalido_d = invalido_q | (boton_pres > 4'd10);
  end
`endif

  // Pending floors above / below the cabin, from registered vectors
  always_comb begin
    req    = cabina_q | sube_q | baja_q;
    arriba = 1'b0;
    abajo  = 1'b0;
    for (int unsigned f = 0; f < NPISOS; f++) begin
      if (req[f] && (2'(f) > piso_actual)) arriba = 1'b1;
      if (req[f] && (2'(f) < piso_actual)) abajo  = 1'b1;
    end
  end

  // Scan FSM next state and destination for the new state
  always_comb begin
    dir_d     = dir_q;
    destino_d = piso_actual;
    case (dir_q)
      REPOSO: begin
        if (arriba)     dir_d = SUBIENDO;
        else if (abajo) dir_d = BAJANDO;
      end
      SUBIENDO: begin
        if (!arriba) dir_d = abajo ? BAJANDO : REPOSO;
      end
      BAJANDO: begin
        if (!abajo) dir_d = arriba ? SUBIENDO : REPOSO;
      end
      default: dir_d = REPOSO;
    endcase
    if (dir_d == SUBIENDO) begin
      // descending scan leaves the lowest floor above the cabin
      for (int f = NPISOS - 1; f >= 0; f--) begin
        if (req[f] && (2'(f) > piso_actual)) destino_d = 2'(f);
      end
    end else if (dir_d == BAJANDO) begin
      for (int unsigned f = 0; f < NPISOS; f++) begin
        if (req[f] && (2'(f) < piso_actual)) destino_d = 2'(f);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cod_prev_q <= 4'd0;
      cabina_q   <= 4'd0;
      sube_q     <= 4'd0;
      baja_q     <= 4'd0;
      nueva_q    <= 1'b0;
      hay_q      <= 1'b0;
      dir_q      <= REPOSO;
      destino_q  <= 2'd0;
    end else begin
      cod_prev_q <= cod_prev_d;
      cabina_q   <= cabina_d;
      sube_q     <= sube_d;
      baja_q     <= baja_d;
      nueva_q    <= nueva_d;
      hay_q      <= hay_d;
      dir_q      <= dir_d;
      destino_q  <= destino_d;
    end
  end

`ifdef CODIGO_INVALIDO_EN
  always_ff @(posedge clk) begin
    if (reset) invalido_q <= 1'b0;
    else       invalido_q <= invalido_d;
  end
  assign codigo_invalido = invalido_q;
`endif

  assign solic_cabina    = cabina_q;
  assign solic_sube      = sube_q;
  assign solic_baja      = baja_q;
  assign nueva_solicitud = nueva_q;
  assign hay_solicitud   = hay_q;
  assign direccion       = dir_q;
  assign piso_destino    = destino_q;

endmodule

// File: tb/tb_registro_solicitudes.sv
// Directed bench for registro_solicitudes: capture, clear, conflict and scan order.
module tb_registro_solicitudes;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] boton_pres;
  logic [1:0] piso_actual;
  logic       atender;
  logic [3:0] solic_cabina, solic_sube, solic_baja;
  logic       nueva_solicitud, hay_solicitud;
  logic [1:0] direccion, piso_destino;
`ifdef CODIGO_INVALIDO_EN
  logic       codigo_invalido;
`endif

  int errors = 0;
  int checks = 0;

  registro_solicitudes dut (
    .clk             (clk),
    .reset           (reset),
    .boton_pres      (boton_pres),
    .piso_actual     (piso_actual),
    .atender         (atender),
    .solic_cabina    (solic_cabina),
    .solic_sube      (solic_sube),
    .solic_baja      (solic_baja),
    .nueva_solicitud (nueva_solicitud),
    .hay_solicitud   (hay_solicitud),
    .direccion       (direccion),
`ifdef CODIGO_INVALIDO_EN
    .codigo_invalido (codigo_invalido),
`endif
    .piso_destino    (piso_destino)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; boton_pres = 4'd0; atender = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; boton_pres = 4'd0; piso_actual = 2'd0; atender = 1'b0;

    // Reset then idle
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("idle_cab",   solic_cabina, 4'b0000);
    chk("idle_sube",  solic_sube,   4'b0000);
    chk("idle_baja",  solic_baja,   4'b0000);
    chk("idle_nueva", {3'b0, nueva_solicitud}, 4'd0);
    chk("idle_hay",   {3'b0, hay_solicitud},   4'd0);
    chk("idle_dir",   {2'b0, direccion},       4'd0);
    chk("idle_dest",  {2'b0, piso_destino},    4'd0);
`ifdef CODIGO_INVALIDO_EN
    chk("idle_inv",   {3'b0, codigo_invalido}, 4'd0);
`endif

    // Held button: code 3 at floor 0
    piso_actual = 2'd0; boton_pres = 4'd3;
    step();
    chk("held_cab1",   solic_cabina, 4'b0100);
    chk("held_nueva1", {3'b0, nueva_solicitud}, 4'd1);
    chk("held_hay1",   {3'b0, hay_solicitud},   4'd1);
    chk("held_dir1",   {2'b0, direccion},       4'd0);
    step();
    chk("held_nueva2", {3'b0, nueva_solicitud}, 4'd0);
    chk("held_dir2",   {2'b0, direccion},       4'd1);
    chk("held_dest2",  {2'b0, piso_destino},    4'd2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("held_nueva_hold", {3'b0, nueva_solicitud}, 4'd0);
    end
    chk("held_cab_end", solic_cabina, 4'b0100);

    // Scan order at floor 1: cabin 4 (idx 3) and S1 (idx 0)
    do_reset();
    piso_actual = 2'd1; boton_pres = 4'd4;
    step();
    chk("scan_cab", solic_cabina, 4'b1000);
    boton_pres = 4'd5;
    step();
    chk("scan_sube", solic_sube, 4'b0001);
    chk("scan_dir1",  {2'b0, direccion},    4'd1);
    chk("scan_dest1", {2'b0, piso_destino}, 4'd3);
    boton_pres = 4'd0;
    step();
    chk("scan_dest2", {2'b0, piso_destino}, 4'd3);
    piso_actual = 2'd2;
    step();
    chk("scan_dest3", {2'b0, piso_destino}, 4'd3);
    piso_actual = 2'd3; atender = 1'b1;
    step();
    atender = 1'b0;
    chk("scan_clr_cab",  solic_cabina, 4'b0000);
    chk("scan_clr_sube", solic_sube,   4'b0001);
    step();
    chk("scan_dir_baj",  {2'b0, direccion},    4'd2);
    chk("scan_dest_baj", {2'b0, piso_destino}, 4'd0);

    // Set/clear conflict at floor 2
    do_reset();
    piso_actual = 2'd2; boton_pres = 4'd3; atender = 1'b1;
    step();
    chk("conf_cab",   solic_cabina, 4'b0000);
    chk("conf_nueva", {3'b0, nueva_solicitud}, 4'd0);
    chk("conf_hay",   {3'b0, hay_solicitud},   4'd0);
    boton_pres = 4'd7;
    step();
    atender = 1'b0;
    chk("conf_sube",   solic_sube,   4'b0010);
    chk("conf_cab2",   solic_cabina, 4'b0000);
    chk("conf_nueva2", {3'b0, nueva_solicitud}, 4'd1);

    // Redundant and invalid codes
    do_reset();
    piso_actual = 2'd0;
    boton_pres = 4'd0;  step();
    boton_pres = 4'd12; step();
    chk("inv_hay",   {3'b0, hay_solicitud},   4'd0);
    chk("inv_nueva", {3'b0, nueva_solicitud}, 4'd0);
`ifdef CODIGO_INVALIDO_EN
    chk("inv_flag1", {3'b0, codigo_invalido}, 4'd1);
`endif
    boton_pres = 4'd0;  step();
    boton_pres = 4'd12; step();
    boton_pres = 4'd0;  step();
    chk("inv_hay2", {3'b0, hay_solicitud}, 4'd0);
    boton_pres = 4'd10; step();
    chk("b4_baja",  solic_baja, 4'b1000);
    chk("b4_nueva", {3'b0, nueva_solicitud}, 4'd1);
    step();
    chk("b4_nueva_hold", {3'b0, nueva_solicitud}, 4'd0);
    boton_pres = 4'd0;  step();
    boton_pres = 4'd10; step();
    chk("b4_redund_nueva", {3'b0, nueva_solicitud}, 4'd0);
    chk("b4_redund_baja",  solic_baja, 4'b1000);
`ifdef CODIGO_INVALIDO_EN
    chk("inv_flag_sticky", {3'b0, codigo_invalido}, 4'd1);
`endif

    // Reset mid-operation with code 2 held through reset
    do_reset();
    piso_actual = 2'd0;
    boton_pres = 4'd2; step();
    boton_pres = 4'd4; step();
    chk("mid_cab", solic_cabina, 4'b1010);
    chk("mid_dir", {2'b0, direccion}, 4'd1);
    boton_pres = 4'd2; reset = 1'b1;
    step();
    chk("mid_rst_cab",   solic_cabina, 4'b0000);
    chk("mid_rst_dir",   {2'b0, direccion}, 4'd0);
    chk("mid_rst_hay",   {3'b0, hay_solicitud}, 4'd0);
`ifdef CODIGO_INVALIDO_EN
    chk("mid_rst_inv",   {3'b0, codigo_invalido}, 4'd0);
`endif
    reset = 1'b0;
    step();
    chk("mid_post_cab",   solic_cabina, 4'b0010);
    chk("mid_post_nueva", {3'b0, nueva_solicitud}, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
